// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arb_pkg
//  Description : Shared types and constants for the data-memory arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BURST1 = 2'd1,
        LOCK0  = 2'd2
    } state_t;

    localparam logic GNT_M0       = 1'b0;
    localparam logic GNT_M1       = 1'b1;
    localparam int   STARVE_LIMIT = 2;

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter_if
//  Description : One requester port of the data-memory arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if #(
    parameter int DW   = 32,
    parameter int AW   = 32,
    parameter int LENW = 2
) ();
    logic            req;
    logic            we;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wdata;
    logic [LENW-1:0] len;
    logic            ready;
    logic            rvalid;
    logic [DW-1:0]   rdata;

    modport master (
        output req, we, addr, wdata, len,
        input  ready, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata, len,
        output ready, rvalid, rdata
    );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-way round-robin picker; a tie goes to the port not
//                granted last.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  wire logic [1:0] req,
    input  wire logic       last,
    output logic      [1:0] gnt
);
    logic w_last_m1;

    assign w_last_m1 = (last == GNT_M1);
    assign gnt[0]    = req[0] & (~req[1] |  w_last_m1);
    assign gnt[1]    = req[1] & (~req[0] | ~w_last_m1);
endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Shares a single-port data memory between the MEM stage
//                (m0) and a burst-capable debug/loader port (m1).
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DW   = 32,
    parameter int AW   = 32,
    parameter int LENW = 2
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    dmem_arbiter_if.slave      m0,
    dmem_arbiter_if.slave      m1,
    output logic               mem_we,
    output logic [AW-1:0]      mem_addr,
    output logic [DW-1:0]      mem_wdata,
    input  wire logic [DW-1:0] mem_rdata
);
    localparam logic [1:0] c_starve_limit = 2'(STARVE_LIMIT);

    state_t          r_state;
    logic [LENW-1:0] r_beat_cnt;
    logic [AW-1:0]   r_burst_addr;
    logic            r_burst_we;
    logic            r_last_gnt;
    logic [1:0]      r_refuse_cnt;
    logic [AW-1:0]   r_mem_addr;
    logic [DW-1:0]   r_mem_wdata;
    logic            r_m0_rvalid, r_m1_rvalid;
    logic [DW-1:0]   r_m0_rdata,  r_m1_rdata;

    logic [1:0]      w_rr_gnt;
    logic            w_m0_ready, w_m1_ready;
    logic            w_acc0, w_acc1, w_acc;
    logic            w_sel_we;
    logic [AW-1:0]   w_sel_addr, w_sel_addr_al;
    logic [DW-1:0]   w_sel_wdata;
    logic            w_burst_start;
    logic [1:0]      w_refuse_nxt;
    logic            w_unused_m0_len;

    assign w_unused_m0_len = ^m0.len;

    rr_arb2 u_rr_arb2 (
        .req  ({m1.req, m0.req}),
        .last (r_last_gnt),
        .gnt  (w_rr_gnt)
    );

    // Ready is forced low while reset is asserted so no beat can slip through.
    always_comb begin
        w_m0_ready = 1'b0;
        w_m1_ready = 1'b0;
        if (rst_n) begin
            case (r_state)
                IDLE: begin
                    w_m0_ready = w_rr_gnt[0];
                    w_m1_ready = w_rr_gnt[1];
                end
                BURST1:  w_m1_ready = m1.req;
                LOCK0:   w_m0_ready = m0.req;
                default: ;
            endcase
        end
    end

    assign w_acc0        = m0.req & w_m0_ready;
    assign w_acc1        = m1.req & w_m1_ready;
    assign w_acc         = w_acc0 | w_acc1;
    assign w_sel_we      = w_acc0 ? m0.we   : ((r_state == BURST1) ? r_burst_we   : m1.we);
    assign w_sel_addr    = w_acc0 ? m0.addr : ((r_state == BURST1) ? r_burst_addr : m1.addr);
    assign w_sel_addr_al = w_sel_addr & ~AW'(3);
    assign w_sel_wdata   = w_acc0 ? m0.wdata : m1.wdata;
    assign w_burst_start = (r_state == IDLE) & w_acc1 & (m1.len != '0);

    always_comb begin
        w_refuse_nxt = 2'd0;
        if (m0.req && !w_m0_ready) begin
            w_refuse_nxt = (r_refuse_cnt == c_starve_limit) ? r_refuse_cnt : r_refuse_cnt + 2'd1;
        end
    end

    assign mem_we    = w_acc & w_sel_we;
    assign mem_addr  = w_acc ? w_sel_addr_al : r_mem_addr;
    assign mem_wdata = w_acc ? w_sel_wdata   : r_mem_wdata;

    assign m0.ready  = w_m0_ready;
    assign m1.ready  = w_m1_ready;
    assign m0.rvalid = r_m0_rvalid;
    assign m1.rvalid = r_m1_rvalid;
    assign m0.rdata  = r_m0_rdata;
    assign m1.rdata  = r_m1_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_beat_cnt   <= '0;
            r_burst_addr <= '0;
            r_burst_we   <= 1'b0;
            r_last_gnt   <= GNT_M1;
            r_refuse_cnt <= 2'd0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_m0_rvalid  <= 1'b0;
            r_m1_rvalid  <= 1'b0;
            r_m0_rdata   <= '0;
            r_m1_rdata   <= '0;
        end else begin
            r_refuse_cnt <= w_refuse_nxt;
            r_m0_rvalid  <= w_acc0 & ~w_sel_we;
            r_m1_rvalid  <= w_acc1 & ~w_sel_we;
            if (w_acc0 && !w_sel_we) r_m0_rdata <= mem_rdata;
            if (w_acc1 && !w_sel_we) r_m1_rdata <= mem_rdata;
            if (w_acc) begin
                r_mem_addr  <= w_sel_addr_al;
                r_mem_wdata <= w_sel_wdata;
            end

            case (r_state)
                IDLE: begin
                    if (w_acc0) r_last_gnt <= GNT_M0;
                    if (w_acc1) r_last_gnt <= GNT_M1;
                    if (w_burst_start) begin
                        r_beat_cnt   <= m1.len;
                        r_burst_addr <= m1.addr + AW'(4);
                        r_burst_we   <= m1.we;
                        r_state      <= BURST1;
                    end else if (w_refuse_nxt >= c_starve_limit) begin
                        r_state <= LOCK0;
                    end
                end
                BURST1: begin
                    if (w_acc1) begin
                        r_burst_addr <= r_burst_addr + AW'(4);
                        r_beat_cnt   <= r_beat_cnt - LENW'(1);
                        if (r_beat_cnt == LENW'(1)) begin
                            r_last_gnt <= GNT_M1;
                            r_state    <= IDLE;
                        end
                    end
                end
                LOCK0: begin
                    if (w_acc0) begin
                        r_last_gnt <= GNT_M0;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Directed and randomized checks of dmem_arbiter against a
//                cycle-level behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;
    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [31:0] ram    [32];
    logic [31:0] shadow [32];

    int n_err    = 0;
    int n_checks = 0;

    dmem_arbiter_if #(.DW(32), .AW(32), .LENW(2)) m0_if ();
    dmem_arbiter_if #(.DW(32), .AW(32), .LENW(2)) m1_if ();

    dmem_arbiter #(.DW(32), .AW(32), .LENW(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m0        (m0_if),
        .m1        (m1_if),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = ram[mem_addr[6:2]];
    always @(posedge clk) if (mem_we) ram[mem_addr[6:2]] <= mem_wdata;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, want %b at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_burst_left, m_last, m_refuse;
    bit          m_lock, m_bwe, m_rv0, m_rv1;
    logic [31:0] m_baddr, m_haddr, m_hwdata, m_rd0, m_rd1;
    bit          e_r0, e_r1, e_acc, e_we, sw, in_burst;
    logic [31:0] sa, sd, e_addr, e_wd;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk1("rst_m0_ready", m0_if.ready, 1'b0);
            chk1("rst_m1_ready", m1_if.ready, 1'b0);
            chk1("rst_mem_we", mem_we, 1'b0);
            chk32("rst_mem_addr", mem_addr, 32'h0);
            chk32("rst_mem_wdata", mem_wdata, 32'h0);
            chk1("rst_m0_rvalid", m0_if.rvalid, 1'b0);
            chk1("rst_m1_rvalid", m1_if.rvalid, 1'b0);
            chk32("rst_m0_rdata", m0_if.rdata, 32'h0);
            chk32("rst_m1_rdata", m1_if.rdata, 32'h0);
            m_burst_left = 0; m_last = 1; m_refuse = 0; m_lock = 0;
            m_bwe = 0; m_rv0 = 0; m_rv1 = 0; m_baddr = 0;
            m_haddr = 0; m_hwdata = 0; m_rd0 = 0; m_rd1 = 0;
        end else begin
            in_burst = (m_burst_left > 0);
            e_r0 = 0; e_r1 = 0;
            if (m_lock)                       e_r0 = m0_if.req;
            else if (in_burst)                e_r1 = m1_if.req;
            else if (m0_if.req && m1_if.req) begin e_r0 = (m_last == 1); e_r1 = !e_r0; end
            else begin e_r0 = m0_if.req; e_r1 = m1_if.req; end

            sw = 0; sa = 0; sd = 0;
            if (e_r0) begin sw = m0_if.we; sa = m0_if.addr; sd = m0_if.wdata; end
            else if (e_r1) begin
                sw = in_burst ? m_bwe   : m1_if.we;
                sa = in_burst ? m_baddr : m1_if.addr;
                sd = m1_if.wdata;
            end
            e_acc  = e_r0 || e_r1;
            e_we   = e_acc && sw;
            e_addr = e_acc ? (sa & ~32'h3) : m_haddr;
            e_wd   = e_acc ? sd : m_hwdata;

            chk1("m0_ready", m0_if.ready, e_r0);
            chk1("m1_ready", m1_if.ready, e_r1);
            chk1("mem_we", mem_we, e_we);
            chk32("mem_addr", mem_addr, e_addr);
            chk32("mem_wdata", mem_wdata, e_wd);
            chk1("m0_rvalid", m0_if.rvalid, m_rv0);
            chk1("m1_rvalid", m1_if.rvalid, m_rv1);
            chk32("m0_rdata", m0_if.rdata, m_rd0);
            chk32("m1_rdata", m1_if.rdata, m_rd1);

            m_rv0 = e_r0 && !sw;
            m_rv1 = e_r1 && !sw;
            if (m_rv0) m_rd0 = shadow[sa[6:2]];
            if (m_rv1) m_rd1 = shadow[sa[6:2]];
            if (e_we)  shadow[sa[6:2]] = sd;
            if (e_acc) begin m_haddr = e_addr; m_hwdata = e_wd; end

            m_refuse = (m0_if.req && !e_r0) ? m_refuse + 1 : 0;
            if (m_lock) begin
                if (e_r0) begin m_lock = 0; m_last = 0; end
            end else if (in_burst) begin
                if (e_r1) begin
                    m_burst_left--;
                    m_baddr = m_baddr + 32'd4;
                    if (m_burst_left == 0) m_last = 1;
                end
            end else begin
                if (e_r0) m_last = 0;
                if (e_r1) m_last = 1;
                if (e_r1 && m1_if.len != 2'd0) begin
                    m_burst_left = int'(m1_if.len);
                    m_baddr      = m1_if.addr + 32'd4;
                    m_bwe        = m1_if.we;
                end else if (m_refuse >= 2) begin
                    m_lock = 1;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_addr();
        case ($urandom_range(0, 9))
            0:       return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            1:       return $urandom();
            default: return 32'($urandom_range(0, 127));
        endcase
    endfunction

    bit a0, a1;

    initial begin
        for (int i = 0; i < 32; i++) begin
            ram[i]    = 32'(i + 9);
            shadow[i] = 32'(i + 9);
        end
        m0_if.req = 0; m0_if.we = 0; m0_if.addr = 0; m0_if.wdata = 0; m0_if.len = 0;
        m1_if.req = 0; m1_if.we = 0; m1_if.addr = 0; m1_if.wdata = 0; m1_if.len = 0;
        repeat (3) step();
        rst_n = 1'b1;

        // Round-robin tie: first tie after reset goes to m0.
        m0_if.req = 1; m0_if.addr = 32'h0;
        m1_if.req = 1; m1_if.addr = 32'h4;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk1("rr_m0_ready", m0_if.ready, (i % 2) == 0);
            chk1("rr_m1_ready", m1_if.ready, (i % 2) == 1);
            step();
        end
        m0_if.req = 0; m1_if.req = 0;
        step();

        // m1 preloaded read.
        m1_if.req = 1; m1_if.we = 0; m1_if.addr = 32'h08; m1_if.len = 0;
        @(negedge clk); chk1("pre_m1_ready", m1_if.ready, 1'b1);
        step(); m1_if.req = 0;
        @(negedge clk); chk1("pre_rvalid", m1_if.rvalid, 1'b1); chk32("pre_rdata", m1_if.rdata, 32'h0000_000B);
        step();
        @(negedge clk); chk1("pre_rvalid_pulse", m1_if.rvalid, 1'b0);

        // m0 write then read.
        m0_if.req = 1; m0_if.we = 1; m0_if.addr = 32'h14; m0_if.wdata = 32'hAA;
        @(negedge clk);
        chk1("wr_mem_we", mem_we, 1'b1); chk32("wr_mem_addr", mem_addr, 32'h14); chk32("wr_mem_wdata", mem_wdata, 32'hAA);
        step(); m0_if.we = 0;
        @(negedge clk); chk1("rd_mem_we", mem_we, 1'b0); chk1("rd_m0_ready", m0_if.ready, 1'b1);
        step(); m0_if.req = 0;
        @(negedge clk); chk1("rd_m0_rvalid", m0_if.rvalid, 1'b1); chk32("rd_m0_rdata", m0_if.rdata, 32'hAA);
        step();

        // Write burst while m0 waits.
        m0_if.req = 1; m0_if.we = 0; m0_if.addr = 32'h14;
        m1_if.req = 1; m1_if.we = 1; m1_if.addr = 32'h40; m1_if.len = 3; m1_if.wdata = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk32("bw_mem_addr", mem_addr, 32'h40 + 32'(4 * i));
            chk32("bw_mem_wdata", mem_wdata, 32'(i + 1));
            chk1("bw_mem_we", mem_we, 1'b1);
            chk1("bw_m0_ready", m0_if.ready, 1'b0);
            step();
            m1_if.wdata = 32'(i + 2); m1_if.addr = $urandom(); m1_if.we = 0;
        end
        m1_if.req = 0;
        @(negedge clk); chk1("bw_m0_after", m0_if.ready, 1'b1);
        step(); m0_if.req = 0;
        step();

        // Read burst with a two-cycle gap after beat 2.
        m1_if.req = 1; m1_if.we = 0; m1_if.addr = 32'h40; m1_if.len = 3;
        @(negedge clk); chk32("gap_b1", mem_addr, 32'h40);
        step();
        @(negedge clk); chk32("gap_b2", mem_addr, 32'h44);
        step(); m1_if.req = 0;
        @(negedge clk); chk1("gap_stall1", m1_if.ready, 1'b0);
        step();
        @(negedge clk); chk1("gap_stall2", m1_if.ready, 1'b0);
        step(); m1_if.req = 1; m1_if.addr = 32'h100;
        @(negedge clk); chk32("gap_b3", mem_addr, 32'h48); chk32("gap_rd2", m1_if.rdata, 32'd2);
        step();
        @(negedge clk); chk32("gap_b4", mem_addr, 32'h4C); chk32("gap_rd3", m1_if.rdata, 32'd3);
        step(); m1_if.req = 0;
        @(negedge clk); chk32("gap_rd4", m1_if.rdata, 32'd4);
        step();

        // Reset mid-burst: outputs clear at once, next m1 accept uses m1_addr.
        m1_if.req = 1; m1_if.we = 0; m1_if.addr = 32'h40; m1_if.len = 3;
        step(); step();
        rst_n = 1'b0;
        #1;
        chk1("ar_m1_ready", m1_if.ready, 1'b0);
        chk1("ar_m1_rvalid", m1_if.rvalid, 1'b0);
        chk32("ar_m1_rdata", m1_if.rdata, 32'h0);
        chk32("ar_mem_addr", mem_addr, 32'h0);
        chk32("ar_m0_rdata", m0_if.rdata, 32'h0);
        step();
        rst_n = 1'b1;
        m1_if.addr = 32'h10; m1_if.len = 0;
        @(negedge clk); chk32("ar_next_addr", mem_addr, 32'h10); chk1("ar_next_ready", m1_if.ready, 1'b1);
        step(); m1_if.req = 0;
        @(negedge clk); chk32("ar_next_rdata", m1_if.rdata, 32'h0000_000D);
        step();

        // Randomized traffic; requests are held until accepted.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            a0 = m0_if.req && m0_if.ready;
            a1 = m1_if.req && m1_if.ready;
            step();
            if (!m0_if.req || a0) begin
                m0_if.req   = ($urandom_range(0, 1) == 1);
                m0_if.we    = ($urandom_range(0, 1) == 1);
                m0_if.addr  = rnd_addr();
                m0_if.wdata = $urandom();
                m0_if.len   = 2'($urandom_range(0, 3));
            end
            if (!m1_if.req || a1) begin
                m1_if.req   = ($urandom_range(0, 4) < 3);
                m1_if.we    = ($urandom_range(0, 1) == 1);
                m1_if.addr  = rnd_addr();
                m1_if.wdata = $urandom();
                m1_if.len   = ($urandom_range(0, 1) == 1) ? 2'($urandom_range(1, 3)) : 2'd0;
            end
        end
        m0_if.req = 0; m1_if.req = 0;
        repeat (6) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the single-port 32×32-bit data memory of the pipelined CPU. It shares the memory between the pipeline MEM stage (port 0) and the debug/loader port (port 1). Port 1 may issue short fixed-length bursts. The block sits between both requesters and the data memory: it drives the memory's write enable, address and write data, and returns registered read data. Read data arrives from the memory combinationally; writes commit on the rising clock edge.

## Interface
- `DW`, 32, data width.
- `AW`, 32, byte-address width.
- `LENW`, 2, width of the port-1 burst-length field (beats = len+1, max 4).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `m0_req` in 1: port-0 access request; held until accepted.
- `m0_we` in 1: port-0 write (1) / read (0).
- `m0_addr` in AW: port-0 byte address.
- `m0_wdata` in DW: port-0 write data.
- `m0_ready` out 1: port-0 beat accepted this cycle.
- `m0_rvalid` out 1: port-0 read data valid (one-cycle pulse).
- `m0_rdata` out DW: port-0 read data.
- `m1_req`, `m1_we`, `m1_addr`, `m1_wdata`, `m1_ready`, `m1_rvalid`, `m1_rdata`: port 1, same meanings as port 0.
- `m1_len` in LENW: burst beats minus 1; sampled on the first accepted beat only.
- `mem_we` out 1: memory write enable.
- `mem_addr` out AW: memory byte address, with bits [1:0] forced to 0.
- `mem_wdata` out DW: memory write data.
- `mem_rdata` in DW: memory read data (combinational from `mem_addr`).

## Operation
- A beat is accepted in a cycle where `mX_req && mX_ready`.
  - In that same cycle the arbiter drives `mem_*` from the granted port.
  - A write commits at the closing clock edge.
  - A read captures `mem_rdata` into that port's rdata register.
- `mem_we` is 0 in every cycle with no accepted write beat. `mem_addr` and `mem_wdata` hold the last driven value.
- The FSM has three states: IDLE, BURST1, LOCK0.
  - **IDLE**
    - Only m0 requesting: grant m0.
    - Only m1 requesting: grant m1.
    - Both requesting: grant the port not granted last (round-robin `last_gnt`).
    - An m1 accept with `m1_len`>0 loads `beat_cnt`=`m1_len`, loads `burst_addr`=`m1_addr`+4, stores `m1_we` as `burst_we`, and moves to BURST1.
  - **BURST1**
    - Only m1 can be granted; `m1_ready`=`m1_req`.
    - Address comes from `burst_addr`; `m1_addr` and `m1_we` are ignored.
    - Each accepted beat increments `burst_addr` by 4 (wraps modulo 2^AW) and decrements `beat_cnt`.
    - Accepting the beat with `beat_cnt`=1 returns the FSM to IDLE and sets `last_gnt`=1.
    - `m0_ready`=0 throughout.
  - **LOCK0** (starvation guard)
    - Entered from IDLE when m0 has been refused for 2 consecutive cycles.
    - Grants m0 unconditionally when it requests, then returns to IDLE.
- `last_gnt` updates on every accepted single beat. It resets to 1, so m0 wins the first tie.
- `mX_rvalid` pulses for 1 cycle after each accepted read beat and never after a write.
- `mX_rdata` holds its value until the next read response on that port.
- Deasserting `m1_req` mid-burst stalls the burst; the burst does not abort.
- Reset (including mid-burst) applies the following:
  - state=IDLE, `beat_cnt`=0, `burst_addr`=0, `last_gnt`=1, refusal counter=0.
  - `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `m0_ready`=`m1_ready`=0, both rvalid=0, both rdata=0.

## Timing
- Accept: `mX_ready` is combinational from state, `m0_req`, `m1_req` and `last_gnt`. It never depends on `mX_we` or address inputs.
- Read latency: `rvalid`/`rdata` appear exactly 1 cycle after the accept cycle.
- Write latency: data is visible to a read accepted in the next cycle.
- Throughput: 1 beat per cycle. A 4-beat burst takes 4 consecutive cycles if `m1_req` stays high.
- Back-to-back: a single-beat m0 access can follow a burst's last beat in the next cycle.
- Simultaneous requests on the same cycle after m0 was granted go to m1; the next tie goes to m0.

## Structure
- Package `dmem_arb_pkg` holds:
  - state enum (IDLE, BURST1, LOCK0);
  - grant-ID constants `GNT_M0`=0, `GNT_M1`=1;
  - `STARVE_LIMIT`=2.
- Sub-module `rr_arb2` is a 2-way round-robin picker: inputs req[1:0] and last; outputs one-hot gnt. It is instantiated once in IDLE.

## Test plan
- **Reset values:** assert `rst_n`=0 mid-operation → all outputs 0 immediately, without a clock edge. After release, the first tie grants m0.
- **Single-beat write then read:** m0 writes 0x0000_00AA to 0x14, then reads 0x14 → `mem_we` high for 1 cycle; `m0_rvalid` 1 cycle after the read accept with `m0_rdata`=0x0000_00AA.
- **Preloaded read:** m1 reads 0x08 → `m1_rdata`=0x0000_000B and `m1_rvalid` pulses once.
- **Round-robin tie:** both ports request single reads for 4 cycles → grant order m0, m1, m0, m1.
- **Write burst:** m1 write burst with `m1_len`=3 at 0x40, data 1,2,3,4, while m0 requests continuously → `mem_addr` = 0x40, 0x44, 0x48, 0x4C; `m0_ready`=0 for all 4 cycles; m0 is granted in the 5th cycle.
- **Burst with gap and reset:** m1 burst with `m1_req` dropped for 2 cycles after beat 2 → burst resumes at 0x48. A second run asserts reset after beat 2 → IDLE; the next m1 accept uses `m1_addr`, not 0x48.
